sio_half_duplex_ctrl: RTL and testbench
=======================================

// Module: sio_half_duplex_ctrl
// PURPOSE
//  Sequences one 3-wire (half-duplex) SPI master transaction on a shared SIO pin.
//  It drives the pin's tri-state buffer via sio_out/sio_oe: write command byte, dummy turnaround, optional read byte.
//  Generates sclk/cs_n (mode 0: sclk idles low, shift on fall, sample on rise).
//  Guarantees master never drives SIO while peripheral may be driving.
// PARAMETERS
//  CLK_DIV     4  clk cycles per sclk half-period; legal >= 1
//  DATA_W      8  bits per write phase and per read phase, MSB first
//  TURN_CYCLES 1  dummy sclk periods between write and read, sio_oe=0; legal >= 1
// PORTS
//  clk      in   1       system clock, all state updates on rising edge
//  rst_n    in   1       asynchronous active-low reset
//  start    in   1       1-cycle request; sampled only in IDLE
//  rd_en    in   1       latched with start: 1 = write+turn+read, 0 = write only
//  wr_data  in   DATA_W  command byte, latched with start
//  abort    in   1       terminate current transaction early
//  sio_in   in   1       SIO pin value (tri-state buffer input side)
//  sio_out  out  1       data to tri-state buffer 'in'
//  sio_oe   out  1       tri-state buffer ENABLE; 1 = master drives SIO
//  sclk     out  1       serial clock
//  cs_n     out  1       chip select, active low
//  busy     out  1       1 from cycle after accepted start until done
//  done     out  1       1-cycle pulse, same cycle cs_n returns high
//  rd_data  out  DATA_W  last received byte; holds until next read completes
//  rd_valid out  1       1-cycle pulse with done when a read phase completed
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cs_n=1, sclk=0, sio_oe=0, sio_out=0, busy=0, done=0, rd_valid=0, rd_data=0.
//  Half-period counter div_cnt counts CLK_DIV cycles; every phase boundary = div_cnt expiry.
//  IDLE: start=1 -> latch wr_data/rd_en, cs_n<=0, sio_oe<=1, sio_out<=wr_data[DATA_W-1], busy<=1 -> SETUP.
//   start while busy is ignored (no queueing).
//  SETUP: CLK_DIV cycles, sclk low -> WRITE.
//  WRITE: DATA_W sclk pulses; sclk toggles each expiry; on each falling edge shift next bit onto sio_out.
//   After last falling edge: rd_en=1 -> sio_oe<=0 same edge, -> TURN; rd_en=0 -> HOLD (sio_oe<=0).
//  TURN: TURN_CYCLES full sclk pulses, sio_oe=0, sio_in ignored -> READ.
//  READ: DATA_W sclk pulses; sample sio_in on each rising edge into shift reg MSB first; sio_oe=0 throughout.
//   After last falling edge -> HOLD.
//  HOLD: sclk low, cs_n low for CLK_DIV cycles; then cs_n<=1, busy<=0, done<=1 -> IDLE.
//   If read phase completed: rd_data<=shift reg, rd_valid<=1 (same cycle as done).
//  Latency, start edge = cycle 0: done at CLK_DIV*(2+2*DATA_W) write-only;
//   plus 2*CLK_DIV*(TURN_CYCLES+DATA_W) with read. Defaults: 72 / 144.
//  abort=1 in any non-IDLE state: next edge sclk<=0, sio_oe<=0 -> HOLD (full CLK_DIV).
//   rd_valid not asserted, rd_data unchanged. abort in IDLE or HOLD: no effect.
//  Invariant: sio_oe=1 only in SETUP/WRITE; never in TURN/READ/HOLD/IDLE.
//  Invariant: sclk=0 whenever cs_n=1.
//  start and abort in same cycle in IDLE: start accepted, abort ignored.
//  Reset mid-transaction: all outputs to reset values immediately; partial rd data discarded.
// TESTING
//  1 Write-only, wr_data=8'hA5, rd_en=0: sio_out on rises = 1,0,1,0,0,1,0,1.
//    8 sclk pulses, sio_oe falls at cycle 68, done+cs_n high at cycle 72, rd_valid=0.
//  2 Read, wr_data=8'h0B, rd_en=1, model drives 8'h3C after turnaround:
//    sio_oe=0 from cycle 68, 1 dummy pulse, rd_data=8'h3C with rd_valid at cycle 144.
//  3 Assertion over all tests: sio_oe=1 never coincides with TURN/READ.
//    Model oe overlap -> X on bus is flagged as failure.
//  4 abort at cycle 100 of read txn: sclk low next cycle, done 4 cycles later.
//    rd_valid=0, rd_data retains 8'h3C.
//  5 rst_n low at cycle 40 of a write: cs_n=1, sio_oe=0, sclk=0 without clk edge.
//    New start after release completes normally.
//  6 start pulsed at cycle 10 while busy: ignored, exactly one done;
//    CLK_DIV=1 run gives done at cycle 18 write-only.

Source files
------------

// File: rtl/sio_half_duplex_ctrl.sv
// 3-wire half-duplex SPI master (mode 0) on a shared SIO pin: command write,
// turnaround dummy clocks, optional read. Owns the pin's tri-state enable.
module sio_half_duplex_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int DATA_W      = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              abort,
    input  logic              sio_in,
    output logic              sio_out,
    output logic              sio_oe,
    output logic              sclk,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PMAX  = (DATA_W > TURN_CYCLES) ? DATA_W : TURN_CYCLES;
    localparam int TOG_W = $clog2(2 * PMAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] DATA_LAST = TOG_W'(2 * DATA_W - 1);
    localparam logic [TOG_W-1:0] TURN_LAST = TOG_W'(2 * TURN_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TOG_W-1:0]  tog_q, tog_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_q, oe_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rdv_q, rdv_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_cmpl_q, rd_cmpl_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic expiry;
    logic last_fall;
    logic active;

    assign expiry    = (div_q == DIV_LAST);
    // Every clocked phase ends on its last falling sclk edge, leaving sclk low.
    assign last_fall = expiry && sclk_q &&
                       (tog_q == ((state_q == S_TURN) ? TURN_LAST : DATA_LAST));
    assign active    = (state_q == S_SETUP) || (state_q == S_WRITE) ||
                       (state_q == S_TURN)  || (state_q == S_READ);

    always_comb begin
        state_d   = state_q;
        div_d     = (state_q == S_IDLE || expiry) ? '0 : div_q + DIV_W'(1);
        tog_d     = tog_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        oe_d      = oe_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdv_d     = 1'b0;
        rd_en_d   = rd_en_q;
        rd_cmpl_d = rd_cmpl_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_en_d   = rd_en;
                    cs_n_d    = 1'b0;
                    oe_d      = 1'b1;
                    out_d     = wr_data[DATA_W-1];
                    tx_d      = wr_data << 1;
                    busy_d    = 1'b1;
                    rd_cmpl_d = 1'b0;
                    tog_d     = '0;
                    sclk_d    = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (expiry) state_d = S_WRITE;
            end
            S_WRITE, S_TURN, S_READ: begin
                if (expiry) begin
                    sclk_d = ~sclk_q;
                    tog_d  = last_fall ? '0 : tog_q + TOG_W'(1);
                    if (state_q == S_WRITE && sclk_q) begin
                        if (last_fall) begin
                            oe_d    = 1'b0;
                            out_d   = 1'b0;
                            state_d = rd_en_q ? S_TURN : S_HOLD;
                        end else begin
                            out_d = tx_q[DATA_W-1];
                            tx_d  = tx_q << 1;
                        end
                    end
                    if (state_q == S_TURN && last_fall) state_d = S_READ;
                    if (state_q == S_READ) begin
                        if (!sclk_q) rx_d = DATA_W'({rx_q, sio_in});
                        if (last_fall) begin
                            rd_cmpl_d = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (expiry) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (rd_cmpl_q) begin
                        rd_data_d = rx_q;
                        rdv_d     = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the phase logic decided and restarts HOLD timing.
        if (abort && active) begin
            state_d   = S_HOLD;
            sclk_d    = 1'b0;
            oe_d      = 1'b0;
            out_d     = 1'b0;
            div_d     = '0;
            tog_d     = '0;
            rd_cmpl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            tog_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdv_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_cmpl_q <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tog_q     <= tog_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdv_q     <= rdv_d;
            rd_en_q   <= rd_en_d;
            rd_cmpl_q <= rd_cmpl_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign sio_out  = out_q;
    assign sio_oe   = oe_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rdv_q;

endmodule

// File: tb/tb_sio_half_duplex_ctrl.sv
// Bench for sio_half_duplex_ctrl: transaction table with a mode-0 peripheral model,
// plus hand sequences for async reset mid-transaction and CLK_DIV=1 latency.
module tb_sio_half_duplex_ctrl;

    logic       clk, rst_n;
    logic       start, rd_en, abort, sio_in;
    logic [7:0] wr_data;
    logic       sio_out, sio_oe, sclk, cs_n, busy, done, rd_valid;
    logic [7:0] rd_data;

    logic       s1_start, s1_sio_out, s1_sio_oe, s1_sclk, s1_cs_n, s1_busy, s1_done, s1_rd_valid;
    logic [7:0] s1_rd_data;

    int vecs = 0;
    int errs = 0;
    int viol = 0;

    // peripheral model state
    logic [7:0] pdata;
    logic       p_oe, p_bit;
    int         falls, pidx;

    sio_half_duplex_ctrl #(.CLK_DIV(4), .DATA_W(8), .TURN_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .wr_data(wr_data),
        .abort(abort), .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe),
        .sclk(sclk), .cs_n(cs_n), .busy(busy), .done(done),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    sio_half_duplex_ctrl #(.CLK_DIV(1), .DATA_W(8), .TURN_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .rd_en(1'b0), .wr_data(8'hA5),
        .abort(1'b0), .sio_in(1'b0), .sio_out(s1_sio_out), .sio_oe(s1_sio_oe),
        .sclk(s1_sclk), .cs_n(s1_cs_n), .busy(s1_busy), .done(s1_done),
        .rd_data(s1_rd_data), .rd_valid(s1_rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Peripheral: after 8 write falls + 1 turnaround fall, shift pdata out MSB first
    // on falling sclk, release after the final read fall or when cs_n rises.
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) begin
            falls = 0;
            p_oe  = 1'b0;
            p_bit = 1'b0;
        end else begin
            falls = falls + 1;
            if (falls == 9) begin
                p_oe  = 1'b1;
                p_bit = pdata[7];
                pidx  = 6;
            end else if (falls > 9 && falls < 17) begin
                p_bit = pdata[pidx];
                pidx  = pidx - 1;
            end else if (falls >= 17) begin
                p_oe = 1'b0;
            end
        end
    end

    assign sio_in = p_oe ? p_bit : (sio_oe ? sio_out : 1'b0);

    // Bus contention (would be X on a real pin) and sclk-with-cs_n-high watch.
    always @(negedge clk) begin
        if ((sio_oe === 1'b1 && p_oe === 1'b1) || (cs_n === 1'b1 && sclk === 1'b1)) begin
            viol = viol + 1;
            if (viol <= 5)
                $display("FAIL invariant at %0t: sio_oe=%b p_oe=%b cs_n=%b sclk=%b",
                         $time, sio_oe, p_oe, cs_n, sclk);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs = vecs + 1;
        if (act !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rd;
        logic [7:0] wd;
        logic [7:0] pd;
        int         abort_cyc;
        int         restart_cyc;
        int         exp_done;
        logic       exp_rdv;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[6];

    task automatic run(input vec_t v, input int idx);
        int n, done_cyc, oe_fall, rises, extra_done;
        logic [7:0] wbits;
        logic prev_sclk, prev_oe, rdv_at_done, cs_at_done, busy_at_done;
        pdata   = v.pd;
        rd_en   = v.rd;
        wr_data = v.wd;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("v%0d busy_after_start", idx), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d cs_oe_out_after_start", idx), {29'd0, cs_n, sio_oe, sio_out},
            {29'd0, 1'b0, 1'b1, v.wd[7]});
        n = 0; done_cyc = -1; oe_fall = -1; rises = 0; wbits = '0;
        prev_sclk = 1'b0; prev_oe = 1'b1;
        rdv_at_done = 1'b0; cs_at_done = 1'b0; busy_at_done = 1'b1;
        while (done_cyc < 0 && n < 400) begin
            if (v.abort_cyc != 0 && n == v.abort_cyc - 1) abort = 1'b1;
            if (v.restart_cyc != 0 && n == v.restart_cyc - 1) start = 1'b1;
            @(posedge clk);
            #1;
            n = n + 1;
            abort = 1'b0;
            start = 1'b0;
            if (v.abort_cyc != 0 && n == v.abort_cyc)
                chk($sformatf("v%0d abort_sclk_oe", idx), {30'd0, sclk, sio_oe}, 32'd0);
            if (sclk && !prev_sclk) begin
                rises = rises + 1;
                if (rises <= 8) wbits = {wbits[6:0], sio_out};
            end
            if (!sio_oe && prev_oe && oe_fall < 0) oe_fall = n;
            if (done) begin
                done_cyc     = n;
                rdv_at_done  = rd_valid;
                cs_at_done   = cs_n;
                busy_at_done = busy;
            end
            prev_sclk = sclk;
            prev_oe   = sio_oe;
        end
        chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        chk($sformatf("v%0d cs_n_busy_at_done", idx), {30'd0, cs_at_done, busy_at_done}, 32'd2);
        chk($sformatf("v%0d rd_valid_at_done", idx), {31'd0, rdv_at_done}, {31'd0, v.exp_rdv});
        chk($sformatf("v%0d rd_data", idx), {24'd0, rd_data}, {24'd0, v.exp_rd});
        if (v.abort_cyc == 0) begin
            chk($sformatf("v%0d write_bits", idx), {24'd0, wbits}, {24'd0, v.wd});
            chk($sformatf("v%0d oe_fall_cycle", idx), oe_fall, 68);
            chk($sformatf("v%0d sclk_pulses", idx), rises, v.rd ? 17 : 8);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_rdv_drop", idx), {30'd0, done, rd_valid}, 32'd0);
        if (v.restart_cyc != 0) begin
            extra_done = 0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clk);
                #1;
                if (done || busy) extra_done = extra_done + 1;
            end
            chk($sformatf("v%0d ignored_start", idx), extra_done, 0);
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b0, 8'hA5, 8'h00,   0,  0,  72, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h0B, 8'h3C,   0,  0, 144, 1'b1, 8'h3C};
        tbl[2] = '{1'b1, 8'hC3, 8'h55, 100,  0, 104, 1'b0, 8'h3C};
        tbl[3] = '{1'b1, 8'h5A, 8'h96,   0,  0, 144, 1'b1, 8'h96};
        tbl[4] = '{1'b0, 8'hFF, 8'h00,  34,  0,  38, 1'b0, 8'h96};
        tbl[5] = '{1'b0, 8'h81, 8'h00,   0, 10,  72, 1'b0, 8'h96};

        rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; abort = 1'b0; wr_data = '0;
        s1_start = 1'b0; pdata = '0;
        #22;
        chk("reset_outputs", {25'd0, cs_n, sclk, sio_oe, sio_out, busy, done, rd_valid},
            {25'd0, 7'b1000000});
        chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start and abort together in IDLE: start wins
        @(negedge clk);
        rd_en = 1'b0; wr_data = 8'h11; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", {30'd0, busy, cs_n}, 32'd2);
        repeat (80) @(posedge clk);
        #1;
        chk("start_abort_txn_idle", {30'd0, busy, cs_n}, 32'd1);

        for (int i = 0; i < 6; i++) run(tbl[i], i);

        // async reset in the middle of a write
        @(negedge clk);
        rd_en = 1'b0; wr_data = 8'hA5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (n = 0; n < 40; n++) @(posedge clk);
        #3;
        chk("pre_reset_active", {31'd0, cs_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {28'd0, cs_n, sio_oe, sclk, busy}, 32'h8);
        @(negedge clk);
        rst_n = 1'b1;
        run(tbl[0], 6);

        // CLK_DIV=1 instance, write-only latency
        @(negedge clk);
        s1_start = 1'b1;
        @(posedge clk);
        #1;
        s1_start = 1'b0;
        n = 0;
        while (!s1_done && n < 100) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("div1_done_cycle", n, 18);

        chk("invariant_violations", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
